wave_capture: RTL and testbench

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture.sv | 138 +++++++++++++
 tb/tb_wave_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture
// Description : Triggered single-frame waveform capture into block RAM with
//               a registered display read port and timeout auto-trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture #(
    parameter int DEPTH   = 640,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [11:0]  sample_in,
    input  logic                sample_valid,
    input  logic signed [11:0]  trig_level,
    input  logic                trig_edge,
    input  logic                arm,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic signed [11:0]  rd_data,
    output logic                frame_ready,
    output logic                busy,
    output logic                auto_trig
);

    // The counter only has to reach TIMEOUT-1; reaching it forces the trigger.
    localparam int                c_TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_wr_ptr;
    logic [c_TMO_W-1:0]      r_tmo_cnt;
    logic signed [11:0]      r_prev;
    logic                    r_prev_valid;
    logic signed [11:0]      r_mem [0:DEPTH-1];

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_level_hit;
    logic                    w_tmo_hit;
    logic                    w_trigger;
    logic                    w_cap_wr;
    logic                    w_wr_en;
    logic [ADDR_W-1:0]       w_wr_addr;

    assign w_rise      = r_prev_valid && (r_prev < trig_level) && (sample_in >= trig_level);
    assign w_fall      = r_prev_valid && (r_prev > trig_level) && (sample_in <= trig_level);
    assign w_level_hit = trig_edge ? w_fall : w_rise;
    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);
    assign w_trigger   = (r_state == WAIT_TRIG) && sample_valid && (w_level_hit || w_tmo_hit);
    assign w_cap_wr    = (r_state == CAPTURE) && sample_valid;
    assign w_wr_en     = w_trigger || w_cap_wr;
    assign w_wr_addr   = w_trigger ? '0 : r_wr_ptr;

    assign busy = (r_state == WAIT_TRIG) || (r_state == CAPTURE);

    // Buffer has no reset so it infers block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= sample_in;
        end
    end

    // Read-before-write: a same-address write is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_tmo_cnt    <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            frame_ready  <= 1'b0;
            auto_trig    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (arm) begin
                        r_state      <= WAIT_TRIG;
                        r_wr_ptr     <= '0;
                        r_tmo_cnt    <= '0;
                        r_prev_valid <= 1'b0;
                        frame_ready  <= 1'b0;
                        auto_trig    <= 1'b0;
                    end
                end
                WAIT_TRIG: begin
                    if (sample_valid) begin
                        r_prev       <= sample_in;
                        r_prev_valid <= 1'b1;
                        if (w_trigger) begin
                            // A genuine crossing wins over a coincident timeout.
                            auto_trig <= !w_level_hit;
                            if (DEPTH == 1) begin
                                r_state     <= DONE;
                                frame_ready <= 1'b1;
                            end else begin
                                r_wr_ptr <= ADDR_W'(1);
                                r_state  <= CAPTURE;
                            end
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        if (r_wr_ptr == c_LAST_ADDR) begin
                            r_state     <= DONE;
                            frame_ready <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_capture
// Description : Scoreboard bench for wave_capture (DEPTH=8, TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_capture;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 16;

    logic                clk;
    logic                rst_n;
    logic signed [11:0]  sample_in;
    logic                sample_valid;
    logic signed [11:0]  trig_level;
    logic                trig_edge;
    logic                arm;
    logic [ADDR_W-1:0]   rd_addr;
    logic signed [11:0]  rd_data;
    logic                frame_ready;
    logic                busy;
    logic                auto_trig;

    wave_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_edge    (trig_edge),
        .arm          (arm),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .auto_trig    (auto_trig)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb_q[$];
    int  exp_mem [DEPTH];
    int  errors = 0;
    int  checks = 0;

    // Reference model of the capture controller
    int  m_state;
    int  m_prev;
    bit  m_pv;
    int  m_cnt;
    int  m_ptr;
    bit  m_fr;
    bit  m_auto;
    int  m_lvl;
    bit  m_edge;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int a, input int s);
        wr_t e;
        e.addr = a;
        e.data = s;
        sb_q.push_back(e);
        exp_mem[a] = s;
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_pv = 0; m_cnt = 0; m_ptr = 0; m_fr = 0; m_auto = 0;
    endtask

    task automatic model_edge(input bit a, input bit v, input int s);
        bit lvl_hit;
        bit to_hit;
        case (m_state)
            0, 3: begin
                if (a) begin
                    m_state = 1; m_fr = 0; m_auto = 0; m_pv = 0; m_cnt = 0;
                end
            end
            1: begin
                if (v) begin
                    if (!m_edge) lvl_hit = m_pv && (m_prev < m_lvl) && (s >= m_lvl);
                    else         lvl_hit = m_pv && (m_prev > m_lvl) && (s <= m_lvl);
                    to_hit = (m_cnt == TIMEOUT - 1);
                    if (lvl_hit || to_hit) begin
                        push_exp(0, s);
                        m_auto  = !lvl_hit;
                        m_ptr   = 1;
                        m_state = 2;
                    end else begin
                        m_cnt++;
                    end
                    m_prev = s;
                    m_pv   = 1;
                end
            end
            2: begin
                if (v) begin
                    push_exp(m_ptr, s);
                    if (m_ptr == DEPTH - 1) begin
                        m_state = 3;
                        m_fr    = 1;
                    end else begin
                        m_ptr++;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic cfg(input int lvl, input bit edg);
        trig_level = 12'(lvl);
        trig_edge  = edg;
        m_lvl      = lvl;
        m_edge     = edg;
    endtask

    task automatic send(input bit a, input bit v, input int s);
        arm          = a;
        sample_valid = v;
        sample_in    = 12'(s);
        model_edge(a, v, s);
        step();
        arm          = 1'b0;
        sample_valid = 1'b0;
        chk("frame_ready", frame_ready, m_fr);
        chk("busy", busy, (m_state == 1 || m_state == 2));
        chk("auto_trig", auto_trig, m_auto);
    endtask

    task automatic drain();
        wr_t e;
        while (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            rd_addr = ADDR_W'(e.addr);
            step();
            chk($sformatf("rd[%0d]", e.addr), rd_data, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t2 [10] = '{300, 150, 100, 50, 0, -50, -100, -150, -200, -250};
        clk = 0; rst_n = 0; sample_in = '0; sample_valid = 0;
        trig_level = '0; trig_edge = 0; arm = 0; rd_addr = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 0;

        #12;
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_auto_trig", auto_trig, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1;
        step();

        // Rising-edge trigger
        cfg(0, 0);
        send(1, 0, 0);
        send(0, 1, -100);
        send(0, 1, -50);
        for (int k = 1; k <= 8; k++) send(0, 1, 20 * k);
        drain();

        // Falling-edge trigger, equality counts
        cfg(100, 1);
        send(1, 0, 0);
        foreach (t2[i]) send(0, 1, t2[i]);
        drain();

        // Timeout auto-trigger on a flat signal
        cfg(0, 0);
        send(1, 0, 0);
        for (int k = 0; k < 23; k++) send(0, 1, 500);
        drain();

        // Gapped valid with arm pulses during capture
        cfg(0, 0);
        send(1, 0, 0);
        send(0, 1, -10);
        send(0, 1, 5);
        for (int i = 1; i <= 7; i++) begin
            send(i % 2, 0, 999);
            send(i == 3, 1, i * 11);
        end
        send(0, 0, 999);
        drain();

        // Registered read latency
        rd_addr = 3'd0;
        step();
        rd_addr = 3'd3;
        #2;
        chk("rd_lat_old", rd_data, exp_mem[0]);
        step();
        chk("rd_lat_new", rd_data, exp_mem[3]);

        // Reset mid-capture after four writes
        cfg(0, 0);
        send(1, 0, 0);
        send(0, 1, -10);
        send(0, 1, 40);
        send(0, 1, 41);
        send(0, 1, 42);
        send(0, 1, 43);
        #2;
        rst_n = 0;
        #1;
        chk("arst_frame_ready", frame_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd_data", rd_data, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        send(0, 1, -100);
        send(0, 1, 100);
        drain();
        rd_addr = 3'd5;
        step();
        chk("kept_after_reset", rd_data, exp_mem[5]);

        // Fresh full frame after reset
        send(1, 0, 0);
        send(0, 1, -10);
        for (int k = 1; k <= 8; k++) send(0, 1, 7 * k);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
